// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
// Bus command encodings and tag width mirror the system bus definitions.
package mem_arbiter_pkg;

   localparam int CMD_W    = 2;
   localparam int TAG_W    = 4;
   localparam int ADDR_W   = 64;
   localparam int DATA_W   = 64;
   localparam int NUM_TAGS = 15;

   localparam int STARVE_MAX_DEFAULT = 4;

   typedef enum logic [CMD_W-1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_e;

   typedef enum logic {
      OWN_ICACHE = 1'b0,
      OWN_DCACHE = 1'b1
   } owner_e;

   typedef enum logic {
      PRIO_D = 1'b0,
      PRIO_I = 1'b1
   } prio_e;

   function automatic logic [TAG_W-1:0] popcount(input logic [NUM_TAGS:1] v);
      logic [TAG_W-1:0] cnt;
      cnt = '0;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         cnt = cnt + TAG_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/memory side signal bundle of the arbiter; slave is the arbiter,
// master is whatever drives the caches and memory (normally a testbench).
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic [CMD_W-1:0]  icache2arb_command_i;
   logic [ADDR_W-1:0] icache2arb_addr_i;
   logic [CMD_W-1:0]  dcache2arb_command_i;
   logic [ADDR_W-1:0] dcache2arb_addr_i;
   logic [DATA_W-1:0] dcache2arb_data_i;

   logic [TAG_W-1:0]  arb2icache_response_o;
   logic [TAG_W-1:0]  arb2icache_tag_o;
   logic [DATA_W-1:0] arb2icache_data_o;
   logic [TAG_W-1:0]  arb2dcache_response_o;
   logic [TAG_W-1:0]  arb2dcache_tag_o;
   logic [DATA_W-1:0] arb2dcache_data_o;

   logic [CMD_W-1:0]  proc2mem_command_o;
   logic [ADDR_W-1:0] proc2mem_addr_o;
   logic [DATA_W-1:0] proc2mem_data_o;
   logic [TAG_W-1:0]  mem2proc_response_i;
   logic [TAG_W-1:0]  mem2proc_tag_i;
   logic [DATA_W-1:0] mem2proc_data_i;

   logic [TAG_W-1:0]  arb_outstanding_o;
   logic              arb_tag_err_o;

   modport slave (
      input  icache2arb_command_i, icache2arb_addr_i,
      input  dcache2arb_command_i, dcache2arb_addr_i, dcache2arb_data_i,
      output arb2icache_response_o, arb2icache_tag_o, arb2icache_data_o,
      output arb2dcache_response_o, arb2dcache_tag_o, arb2dcache_data_o,
      output proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
      input  mem2proc_response_i, mem2proc_tag_i, mem2proc_data_i,
      output arb_outstanding_o, arb_tag_err_o
   );

   modport master (
      output icache2arb_command_i, icache2arb_addr_i,
      output dcache2arb_command_i, dcache2arb_addr_i, dcache2arb_data_i,
      input  arb2icache_response_o, arb2icache_tag_o, arb2icache_data_o,
      input  arb2dcache_response_o, arb2dcache_tag_o, arb2dcache_data_o,
      input  proc2mem_command_o, proc2mem_addr_o, proc2mem_data_o,
      output mem2proc_response_i, mem2proc_tag_i, mem2proc_data_i,
      input  arb_outstanding_o, arb_tag_err_o
   );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Owner table for memory tags 1..15: which cache issued the load behind each tag.
// A write and a clear to the same tag in one cycle leave the entry valid with the new owner.
module arb_tag_table
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  owner_e           wr_owner_i,
   input  logic             clr_en_i,
   input  logic [TAG_W-1:0] clr_tag_i,
   input  logic [TAG_W-1:0] lk_tag_i,
   output logic             lk_valid_o,
   output owner_e           lk_owner_o,
   output logic [TAG_W-1:0] count_o
);

   logic [NUM_TAGS:1] valid_q, valid_d;
   owner_e            owner_q [NUM_TAGS:1];
   owner_e            owner_d [NUM_TAGS:1];
   logic [TAG_W-1:0]  count_q;

   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         if (clr_en_i && clr_tag_i == TAG_W'(i)) begin
            valid_d[i] = 1'b0;
         end
         if (wr_en_i && wr_tag_i == TAG_W'(i)) begin
            valid_d[i] = 1'b1;
            owner_d[i] = wr_owner_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= popcount(valid_d);
      end
   end

   // Owner bits only matter while the matching valid bit is set, so they carry no reset.
   always_ff @(posedge clk) begin
      owner_q <= owner_d;
   end

   always_comb begin
      lk_valid_o = 1'b0;
      lk_owner_o = OWN_ICACHE;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         if (lk_tag_i == TAG_W'(i)) begin
            lk_valid_o = valid_q[i];
            lk_owner_o = owner_q[i];
         end
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache-first grant with icache anti-starvation,
// and tag-based routing of memory responses back to the cache that issued the load.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

   prio_e            prio_q, prio_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             err_q, err_d;

   logic             i_req, d_req, d_is_load;
   logic             grant_i, grant_d;
   logic             alloc_en, ret_hit, clr_en;
   owner_e           alloc_owner, lk_owner;
   logic             lk_valid;
   logic [TAG_W-1:0] resp, ret_tag;

   assign resp    = bus.mem2proc_response_i;
   assign ret_tag = bus.mem2proc_tag_i;

   // icache only ever loads; anything else from it is treated as idle
   assign i_req     = (bus.icache2arb_command_i == BUS_LOAD);
   assign d_is_load = (bus.dcache2arb_command_i == BUS_LOAD);
   assign d_req     = d_is_load || (bus.dcache2arb_command_i == BUS_STORE);
   assign grant_i   = i_req && (!d_req || prio_q == PRIO_I);
   assign grant_d   = d_req && !grant_i;

   always_comb begin
      bus.proc2mem_command_o = BUS_NONE;
      bus.proc2mem_addr_o    = '0;
      bus.proc2mem_data_o    = '0;
      if (grant_i) begin
         bus.proc2mem_command_o = BUS_LOAD;
         bus.proc2mem_addr_o    = bus.icache2arb_addr_i;
      end else if (grant_d) begin
         bus.proc2mem_command_o = bus.dcache2arb_command_i;
         bus.proc2mem_addr_o    = bus.dcache2arb_addr_i;
         bus.proc2mem_data_o    = bus.dcache2arb_data_i;
      end
   end

   assign bus.arb2icache_response_o = grant_i ? resp : '0;
   assign bus.arb2dcache_response_o = grant_d ? resp : '0;

   // Routing reads the table before this cycle's allocation lands
   assign ret_hit = (ret_tag != '0) && lk_valid;

   always_comb begin
      bus.arb2icache_tag_o  = '0;
      bus.arb2icache_data_o = '0;
      bus.arb2dcache_tag_o  = '0;
      bus.arb2dcache_data_o = '0;
      if (ret_hit) begin
         if (lk_owner == OWN_ICACHE) begin
            bus.arb2icache_tag_o  = ret_tag;
            bus.arb2icache_data_o = bus.mem2proc_data_i;
         end else begin
            bus.arb2dcache_tag_o  = ret_tag;
            bus.arb2dcache_data_o = bus.mem2proc_data_i;
         end
      end
   end

   assign alloc_en    = !rst && (resp != '0) && (grant_i || (grant_d && d_is_load));
   assign alloc_owner = grant_i ? OWN_ICACHE : OWN_DCACHE;
   assign clr_en      = !rst && ret_hit;

   arb_tag_table u_table (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (alloc_en),
      .wr_tag_i   (resp),
      .wr_owner_i (alloc_owner),
      .clr_en_i   (clr_en),
      .clr_tag_i  (ret_tag),
      .lk_tag_i   (ret_tag),
      .lk_valid_o (lk_valid),
      .lk_owner_o (lk_owner),
      .count_o    (bus.arb_outstanding_o)
   );

   always_comb begin
      prio_d   = PRIO_D;
      starve_d = '0;
      err_d    = err_q;
      unique case (prio_q)
         PRIO_D: begin
            if (i_req && grant_d) begin
               if (int'(starve_q) + 1 >= STARVE_MAX) begin
                  prio_d = PRIO_I;
               end else begin
                  starve_d = starve_q + CNT_W'(1);
               end
            end
         end
         PRIO_I: begin
            prio_d = PRIO_D;
         end
         default: prio_d = PRIO_D;
      endcase
      if ((ret_tag != '0) && !lk_valid) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q   <= PRIO_D;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         prio_q   <= prio_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign bus.arb_tag_err_o = err_q;

endmodule
